// File: rtl/rgb_slice_mapper.sv
// rgb_slice_mapper: tags each accepted RGB pixel with its µblock, block and slice
// coordinates, reorders the colour channels, and flags short and long frames.
module rgb_slice_mapper #(
  parameter int PIX_W    = 24,
  parameter int BLOCK_W  = 8,
  parameter int BLOCK_H  = 16,
  parameter int BLOCKS_X = 5,
  parameter int BLOCKS_Y = 3,
  parameter int SLICES   = 128,
  parameter int SWAP_RB  = 1
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [PIX_W-1:0]                                 rgb,
  input  logic                                             hsync,
  input  logic                                             vsync,
  input  logic                                             empty,
  input  logic                                             rgb_enable,
  output logic [PIX_W-1:0]                                 pixel_data,
  output logic                                             pixel_valid,
  output logic [((BLOCK_W  > 1) ? $clog2(BLOCK_W)  : 1)-1:0] pixel_col,
  output logic [((BLOCK_H  > 1) ? $clog2(BLOCK_H)  : 1)-1:0] pixel_line,
  output logic [((BLOCKS_X > 1) ? $clog2(BLOCKS_X) : 1)-1:0] block_col,
  output logic [((BLOCKS_Y > 1) ? $clog2(BLOCKS_Y) : 1)-1:0] block_line,
  output logic [((SLICES   > 1) ? $clog2(SLICES)   : 1)-1:0] slice_cnt,
  output logic                                             eos,
  output logic                                             eof,
  output logic                                             err_short,
  output logic                                             err_long
);

  localparam int PCW = (BLOCK_W  > 1) ? $clog2(BLOCK_W)  : 1;
  localparam int PLW = (BLOCK_H  > 1) ? $clog2(BLOCK_H)  : 1;
  localparam int BCW = (BLOCKS_X > 1) ? $clog2(BLOCKS_X) : 1;
  localparam int BLW = (BLOCKS_Y > 1) ? $clog2(BLOCKS_Y) : 1;
  localparam int SCW = (SLICES   > 1) ? $clog2(SLICES)   : 1;
  localparam int CW  = PIX_W / 3;

  localparam logic [PCW-1:0] PC_MAX = PCW'(BLOCK_W - 1);
  localparam logic [PLW-1:0] PL_MAX = PLW'(BLOCK_H - 1);
  localparam logic [BCW-1:0] BC_MAX = BCW'(BLOCKS_X - 1);
  localparam logic [BLW-1:0] BL_MAX = BLW'(BLOCKS_Y - 1);
  localparam logic [SCW-1:0] SC_MAX = SCW'(SLICES - 1);

  // IDLE: no frame since reset; ACTIVE: frame in progress; DONE: eof issued
  typedef enum logic [1:0] {FR_IDLE, FR_ACTIVE, FR_DONE} frame_t;

  frame_t           r_frame, w_frame_nxt;
  logic             r_vsync;
  logic             r_en;
  logic             r_ovf;
  logic [PCW-1:0]   r_pc, w_pc_nxt;
  logic [PLW-1:0]   r_pl, w_pl_nxt;
  logic [BCW-1:0]   r_bc, w_bc_nxt;
  logic [BLW-1:0]   r_bl, w_bl_nxt;
  logic [SCW-1:0]   r_sc, w_sc_nxt;

  logic             w_acc, w_fs, w_beat, w_drop, w_live;
  logic             w_last_pix, w_eof;
  logic [PIX_W-1:0] w_pix;

  logic [PIX_W-1:0] r_pixel_data;
  logic             r_pixel_valid, r_eos, r_eof, r_err_short, r_err_long;
  logic [PCW-1:0]   r_o_pc;
  logic [PLW-1:0]   r_o_pl;
  logic [BCW-1:0]   r_o_bc;
  logic [BLW-1:0]   r_o_bl;
  logic [SCW-1:0]   r_o_sc;

  // Event decode, frame next-state and next-coordinate counters
  always_comb begin
    w_acc       = !empty;
    w_fs        = w_acc && vsync && !r_vsync;
    w_beat      = w_acc && vsync && hsync && !w_fs;
    w_drop      = w_beat && (r_frame == FR_DONE);
    w_live      = w_beat && !w_drop;
    w_last_pix  = (r_pc == PC_MAX) && (r_bc == BC_MAX) &&
                  (r_pl == PL_MAX) && (r_bl == BL_MAX);
    w_eof       = w_last_pix && (r_sc == SC_MAX);

    w_frame_nxt = r_frame;
    w_pc_nxt    = r_pc;
    w_bc_nxt    = r_bc;
    w_pl_nxt    = r_pl;
    w_bl_nxt    = r_bl;
    w_sc_nxt    = r_sc;

    if (w_fs) begin
      w_frame_nxt = FR_ACTIVE;
      w_pc_nxt    = '0;
      w_bc_nxt    = '0;
      w_pl_nxt    = '0;
      w_bl_nxt    = '0;
      w_sc_nxt    = '0;
    end else if (w_live) begin
      if (w_eof) w_frame_nxt = FR_DONE;
      // Nested wrap with explicit compares so non-power-of-two geometries work
      if (r_pc != PC_MAX) begin
        w_pc_nxt = r_pc + 1'b1;
      end else begin
        w_pc_nxt = '0;
        if (r_bc != BC_MAX) begin
          w_bc_nxt = r_bc + 1'b1;
        end else begin
          w_bc_nxt = '0;
          if (r_pl != PL_MAX) begin
            w_pl_nxt = r_pl + 1'b1;
          end else begin
            w_pl_nxt = '0;
            if (r_bl != BL_MAX) begin
              w_bl_nxt = r_bl + 1'b1;
            end else begin
              w_bl_nxt = '0;
              w_sc_nxt = (r_sc == SC_MAX) ? '0 : r_sc + 1'b1;
            end
          end
        end
      end
    end
  end

  // Channel reorder
  always_comb begin
    w_pix = rgb;
    if (SWAP_RB != 0) w_pix = {rgb[CW-1:0], rgb[2*CW-1:CW], rgb[3*CW-1:2*CW]};
  end

  // Frame state, vsync history, enable latch, overflow flag and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame <= FR_IDLE;
      r_vsync <= 1'b0;
      r_en    <= 1'b0;
      r_ovf   <= 1'b0;
      r_pc    <= '0;
      r_bc    <= '0;
      r_pl    <= '0;
      r_bl    <= '0;
      r_sc    <= '0;
    end else begin
      r_frame <= w_frame_nxt;
      r_pc    <= w_pc_nxt;
      r_bc    <= w_bc_nxt;
      r_pl    <= w_pl_nxt;
      r_bl    <= w_bl_nxt;
      r_sc    <= w_sc_nxt;
      if (w_acc) r_vsync <= vsync;
      if (w_fs) begin
        r_en  <= rgb_enable;
        r_ovf <= 1'b0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Registered output stage: coordinates describe the pixel being output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pixel_data  <= '0;
      r_pixel_valid <= 1'b0;
      r_eos         <= 1'b0;
      r_eof         <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_long    <= 1'b0;
      r_o_pc        <= '0;
      r_o_bc        <= '0;
      r_o_pl        <= '0;
      r_o_bl        <= '0;
      r_o_sc        <= '0;
    end else begin
      r_pixel_valid <= w_live && r_en;
      r_eos         <= w_live && w_last_pix;
      r_eof         <= w_live && w_eof;
      r_err_short   <= w_fs && (r_frame == FR_ACTIVE);
      r_err_long    <= w_drop && !r_ovf;
      if (w_live) begin
        r_pixel_data <= w_pix;
        r_o_pc       <= r_pc;
        r_o_bc       <= r_bc;
        r_o_pl       <= r_pl;
        r_o_bl       <= r_bl;
        r_o_sc       <= r_sc;
      end
    end
  end

  assign pixel_data  = r_pixel_data;
  assign pixel_valid = r_pixel_valid;
  assign pixel_col   = r_o_pc;
  assign pixel_line  = r_o_pl;
  assign block_col   = r_o_bc;
  assign block_line  = r_o_bl;
  assign slice_cnt   = r_o_sc;
  assign eos         = r_eos;
  assign eof         = r_eof;
  assign err_short   = r_err_short;
  assign err_long    = r_err_long;

endmodule

// File: tb/tb_rgb_slice_mapper.sv
// Scoreboard bench: two mapper instances (default geometry, and a small
// non-power-of-two geometry without channel swap) share one input stream.
module tb_rgb_slice_mapper;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] rgb;
  logic        hsync, vsync, empty, rgb_enable;

  always #5 clk = ~clk;

  // Instance A: default parameters
  logic [23:0] a_d;
  logic        a_pv, a_eos, a_eof, a_es, a_el;
  logic [2:0]  a_pc, a_bc;
  logic [3:0]  a_pl;
  logic [1:0]  a_bl;
  logic [6:0]  a_sc;

  rgb_slice_mapper dA (
    .clk(clk), .rst(rst), .rgb(rgb), .hsync(hsync), .vsync(vsync), .empty(empty),
    .rgb_enable(rgb_enable), .pixel_data(a_d), .pixel_valid(a_pv),
    .pixel_col(a_pc), .pixel_line(a_pl), .block_col(a_bc), .block_line(a_bl),
    .slice_cnt(a_sc), .eos(a_eos), .eof(a_eof), .err_short(a_es), .err_long(a_el)
  );

  // Instance B: BLOCK_W=6, BLOCKS_X=3, SLICES=5, no swap
  logic [23:0] b_d;
  logic        b_pv, b_eos, b_eof, b_es, b_el;
  logic [2:0]  b_pc, b_sc;
  logic [1:0]  b_bc, b_bl;
  logic [3:0]  b_pl;

  rgb_slice_mapper #(.BLOCK_W(6), .BLOCKS_X(3), .SLICES(5), .SWAP_RB(0)) dB (
    .clk(clk), .rst(rst), .rgb(rgb), .hsync(hsync), .vsync(vsync), .empty(empty),
    .rgb_enable(rgb_enable), .pixel_data(b_d), .pixel_valid(b_pv),
    .pixel_col(b_pc), .pixel_line(b_pl), .block_col(b_bc), .block_line(b_bl),
    .slice_cnt(b_sc), .eos(b_eos), .eof(b_eof), .err_short(b_es), .err_long(b_el)
  );

  typedef struct packed {
    logic        pv;
    logic [23:0] d;
    logic [7:0]  pc, bc, pl, bl, sl;
    logic        eos, eof, es, el;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];

  int errors = 0;
  int checks = 0;
  int pv_b   = 0;

  // Reference model state, one slot per instance
  logic m_vs[2], m_st[2], m_cp[2], m_ov[2], m_en[2];
  int   m_n[2];

  task automatic push(input int i, input rec_t r);
    if (i == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_vs[i] = 1'b0; m_st[i] = 1'b0; m_cp[i] = 1'b0;
      m_ov[i] = 1'b0; m_en[i] = 1'b0; m_n[i] = 0;
    end
  endtask

  // Coordinates derived from the beat index by division, not by counting
  task automatic model(input int i, input logic e, input logic vs, input logic hs,
                       input logic en_in, input logic [23:0] d);
    int   bw, bx, spx, ns, n;
    logic fs;
    rec_t r;
    bw = (i == 0) ? 8 : 6;
    bx = (i == 0) ? 5 : 3;
    ns = (i == 0) ? 128 : 5;
    spx = bw * bx * 16 * 3;
    r = '0;
    if (e) return;
    fs = vs && !m_vs[i];
    m_vs[i] = vs;
    if (fs) begin
      if (m_st[i] && !m_cp[i]) begin r.es = 1'b1; push(i, r); end
      m_st[i] = 1'b1; m_cp[i] = 1'b0; m_ov[i] = 1'b0; m_n[i] = 0; m_en[i] = en_in;
    end else if (vs && hs) begin
      if (m_cp[i]) begin
        if (!m_ov[i]) begin r.el = 1'b1; push(i, r); end
        m_ov[i] = 1'b1;
      end else begin
        n     = m_n[i];
        r.pc  = 8'(n % bw);
        r.bc  = 8'((n / bw) % bx);
        r.pl  = 8'((n / (bw * bx)) % 16);
        r.bl  = 8'((n / (bw * bx * 16)) % 3);
        r.sl  = 8'(n / spx);
        r.eos = ((n + 1) % spx) == 0;
        r.eof = r.eos && (n / spx == ns - 1);
        r.pv  = m_en[i];
        r.d   = (i == 0) ? {d[7:0], d[15:8], d[23:16]} : d;
        if (r.eof) m_cp[i] = 1'b1;
        m_n[i] = n + 1;
        if (r.pv || r.eos) push(i, r);
      end
    end
  endtask

  task automatic mon(input int i, input logic pv, input logic [23:0] d,
                     input logic [7:0] pc, input logic [7:0] bc, input logic [7:0] pl,
                     input logic [7:0] bl, input logic [7:0] sl,
                     input logic eos_i, input logic eof_i, input logic es, input logic el);
    rec_t g, x;
    if (!(pv || eos_i || eof_i || es || el)) return;
    checks++;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_output inst=%0d pv=%b eos=%b eof=%b es=%b el=%b required=none",
               i, pv, eos_i, eof_i, es, el);
      return;
    end
    if (i == 0) x = q0.pop_front();
    else        x = q1.pop_front();
    g = '{pv, d, pc, bc, pl, bl, sl, eos_i, eof_i, es, el};
    if (!x.pv) begin g.d = '0; x.d = '0; end
    if (!(x.pv || x.eos)) begin
      g.pc = '0; g.bc = '0; g.pl = '0; g.bl = '0; g.sl = '0;
      x.pc = '0; x.bc = '0; x.pl = '0; x.bl = '0; x.sl = '0;
    end
    if (g !== x) begin
      errors++;
      $display("FAIL output_record inst=%0d got pv=%b d=%h pc=%0d bc=%0d pl=%0d bl=%0d sl=%0d eos=%b eof=%b es=%b el=%b required pv=%b d=%h pc=%0d bc=%0d pl=%0d bl=%0d sl=%0d eos=%b eof=%b es=%b el=%b",
               i, g.pv, g.d, g.pc, g.bc, g.pl, g.bl, g.sl, g.eos, g.eof, g.es, g.el,
               x.pv, x.d, x.pc, x.bc, x.pl, x.bl, x.sl, x.eos, x.eof, x.es, x.el);
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_pv, a_d, 8'(a_pc), 8'(a_bc), 8'(a_pl), 8'(a_bl), 8'(a_sc), a_eos, a_eof, a_es, a_el);
  end

  always @(negedge clk) begin
    mon(1, b_pv, b_d, 8'(b_pc), 8'(b_bc), 8'(b_pl), 8'(b_bl), 8'(b_sc), b_eos, b_eof, b_es, b_el);
    if (b_pv) pv_b++;
  end

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // One clock: drive, update the model, advance to #1 after the edge
  task automatic cyc(input logic e, input logic vs, input logic hs, input logic en,
                     input logic [23:0] d);
    empty = e; vsync = vs; hsync = hs; rgb_enable = en; rgb = d;
    model(0, e, vs, hs, en, d);
    model(1, e, vs, hs, en, d);
    @(posedge clk);
    #1;
  endtask

  logic en_cur;

  task automatic beats(input int n, input int bubble_pct);
    logic [23:0] d;
    for (int k = 0; k < n; k++) begin
      d = {8'(k), 8'(k >> 8), 8'(k * 5)};
      if (int'($urandom_range(99)) < bubble_pct)
        cyc(1'b1, $urandom_range(1), $urandom_range(1), en_cur, 24'hDEAD00);
      if (k % 37 == 36) cyc(1'b0, 1'b1, 1'b0, en_cur, 24'h0);
      cyc(1'b0, 1'b1, 1'b1, en_cur, d);
    end
  endtask

  task automatic idle(input int n, input logic e);
    for (int k = 0; k < n; k++) cyc(e, 1'b0, 1'b0, en_cur, 24'h0);
  endtask

  initial begin
    model_reset();
    rst = 1'b1; en_cur = 1'b1;
    empty = 1'b1; vsync = 1'b0; hsync = 1'b0; rgb_enable = 1'b0; rgb = '0;
    @(posedge clk); #1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    rst = 1'b0;
    chk("reset_pixel_valid", a_pv, 0);
    chk("reset_pixel_data", a_d, 0);
    chk("reset_flags", {a_eos, a_eof, a_es, a_el}, 0);
    chk("reset_coords", {a_pc, a_bc, a_pl, a_bl, a_sc}, 0);
    chk("reset_b_all", {b_pv, b_eos, b_eof, b_es, b_el, b_pc, b_sc}, 0);

    // Frame 1: start with hsync high carries no pixel, then 0x112233 first
    idle(2, 1'b0);
    en_cur = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 24'h112233);
    chk("start_no_pixel", a_pv, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 24'h112233);
    chk("swap_on_data", a_d, 24'h332211);
    chk("swap_off_data", b_d, 24'h112233);
    chk("first_coords", {a_pc, a_bc, a_pl, a_bl, a_sc}, 0);
    beats(4319, 50);
    beats(3, 0);                           // B is complete: overflow beats
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 24'h0);    // vsync falls with hsync high
    idle(3, 1'b0);
    chk("b_pixel_count_frame", pv_b, 4320);

    // Frame 2: disabled output, aborted after 1000 beats
    en_cur = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 24'h0);
    beats(1000, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    chk("b_pixel_count_disabled", pv_b, 4320);

    // Frame 3: rising vsync hidden by empty, detected on next accepted cycle
    en_cur = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 24'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 24'h0);
    beats(4320, 50);
    idle(3, 1'b0);

    // Frame 4 abandoned by reset; frame 5 must not flag err_short
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 24'h0);
    beats(500, 0);
    idle(3, 1'b1);
    rst = 1'b1;
    model_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 24'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 24'h0);
    rst = 1'b0;
    chk("midframe_reset_valid", {a_pv, b_pv}, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 24'h0);
    beats(200, 25);
    idle(4, 1'b0);

    chk("scoreboard_a_drained", q0.size(), 0);
    chk("scoreboard_b_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_slice_mapper.md
# rgb_slice_mapper

Parametrised successor to the RGB input logic. It accepts the FIFO-fed RGB pixel stream framed by hsync/vsync and tags every accepted pixel with its µblock coordinates, block coordinates and slice index, for any block geometry. It reorders colour channels per a mode parameter, pulses end-of-slice and end-of-frame markers, and reports short and long frames. It sits between the RGB input FIFO and the framebuffer write logic.

## Interface
Parameters:
- PIX_W, 24: pixel width; must be 3×channel width.
- BLOCK_W, 8: pixel columns per µblock.
- BLOCK_H, 16: pixel lines per µblock.
- BLOCKS_X, 5: µblock columns per slice.
- BLOCKS_Y, 3: µblock lines per slice.
- SLICES, 128: slices per frame.
- SWAP_RB, 1: 1 = output {ch0,ch1,ch2} (byte-reversed), 0 = pass-through.

Ports (field widths are clog2 of the count, minimum 1):
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- rgb  in  PIX_W  pixel from FIFO.
- hsync  in  1  line-valid qualifier.
- vsync  in  1  frame-valid qualifier.
- empty  in  1  FIFO empty; the cycle is ignored when high.
- rgb_enable  in  1  enables pixel output; sampled at frame start.
- pixel_data  out  PIX_W  reordered pixel.
- pixel_valid  out  1  pixel_data and coordinates valid.
- pixel_col / pixel_line  out  clog2(BLOCK_W) / clog2(BLOCK_H)  position within the µblock.
- block_col / block_line  out  clog2(BLOCKS_X) / clog2(BLOCKS_Y)  µblock position.
- slice_cnt  out  clog2(SLICES)  slice index of the output pixel.
- eos  out  1  asserted with the last pixel of a slice.
- eof  out  1  asserted with the last pixel of slice SLICES-1.
- err_short  out  1  one-cycle pulse: a frame started before the previous frame completed.
- err_long  out  1  one-cycle pulse: first dropped pixel past the end of a frame.

## Operation
- Accepted cycle: !empty. Non-accepted cycles change no state. vsync_r updates only on accepted cycles.
- Frame start: accepted cycle with vsync & !vsync_r.
  - Clears all next-coordinate counters and slice_cnt.
  - Latches rgb_enable into en_r.
  - Clears the overflow flag.
  - Carries no pixel, even if hsync is high.
  - Pulses err_short if the previous frame was started and not completed. Completed means eof was issued. The very first frame after reset never flags.
- Pixel beat: accepted cycle with vsync & hsync that is not a frame start.
- Counter nesting: pixel_col wraps at BLOCK_W-1, then block_col at BLOCKS_X-1, then pixel_line at BLOCK_H-1, then block_line at BLOCKS_Y-1, then slice.
  - Wraps use an explicit compare. They must not rely on power-of-two overflow.
- Last pixel of a slice (all four fields at max) raises eos. If the slice is also SLICES-1, eof is raised as well and the frame is marked complete.
- Beats after completion set the overflow flag. These beats are dropped (no pixel_valid) and do not advance counters. err_long pulses on the first one only.
- Counting is independent of en_r: errors and eos/eof markers are still generated when en_r=0, with pixel_valid held low.
- Channel order: with SWAP_RB=1, pixel_data = {rgb[7:0], rgb[15:8], rgb[23:16]}, generalised to channel width PIX_W/3.

## Timing
- Registered output stage; latency is 1 cycle from the beat to pixel_valid.
- At that output cycle, coordinates, slice_cnt, eos and eof describe that same pixel.
- pixel_valid = registered (beat & en_r & !overflow).
- eos/eof are gated by the same beat condition minus en_r.
- err_short and err_long are registered, 1 cycle after the triggering accepted cycle.
- All outputs reset to 0. Reset mid-frame abandons the frame; the next frame start does not flag err_short.
- Simultaneous events:
  - vsync falling with hsync high: no beat.
  - empty high masks every event, including edges (the edge is detected on the next accepted cycle).
- Throughput: one pixel per clk, no backpressure.

## Test plan
- Default parameters, rgb_enable=1, one full frame of 128×1920 beats: pixel_valid count is 245760. The first pixel has all coordinates 0. The pixel at beat 1919 has pixel_col 7, block_col 4, pixel_line 15, block_line 2 and eos=1. The last pixel has slice_cnt 127 with eos=eof=1.
- rgb=0x112233 with SWAP_RB=1 gives pixel_data 0x332211. With SWAP_RB=0 it gives 0x112233.
- Random empty bubbles (50%) during a frame: coordinate sequence identical to the bubble-free run, with no gaps in the indices.
- Frame start after 1000 beats: err_short is a single pulse, the counters restart at 0, and the new rgb_enable=0 suppresses all pixel_valid while eos still pulses.
- Non-power-of-two geometry BLOCK_W=6, BLOCKS_X=3, SLICES=5: pixel_col wraps 5→0, and eof fires on beat 5×6×3×16×3.
- After eof, 3 extra beats: err_long pulses once, pixel_valid stays low, and the next frame proceeds normally with no errors.
